dmem_responder: RTL and testbench

Memory-side responder for the CPU data port. Accepts load/store requests from the `mips` core, drives a synchronous single-port data BRAM, and inserts stall cycles so every load waits out the BRAM read latency before its data is returned. Stores are posted in one cycle. The block sits between the core's data interface and the `data_ram` instance in `top`, replacing the direct core-to-BRAM wiring.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_lane_fmt.sv | 73 +++++++
 rtl/dmem_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: encodings shared by the data-memory responder and its lane formatter.
// Holds access-size codes, FSM states and the legal BRAM read-latency range.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    function automatic logic [1:0] clamp_lat(input int unsigned lat);
        if (lat < RD_LAT_MIN) return 2'(RD_LAT_MIN);
        if (lat > RD_LAT_MAX) return 2'(RD_LAT_MAX);
        return 2'(lat);
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: store lane replication/byte enables and load lane extraction.
// Sub-word handling exists only with DMEM_SUBWORD_EN; otherwise word pass-through.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_lo,
    input  logic [31:0] req_wdata,
    output logic        misaligned,
    output logic [3:0]  wea,
    output logic [31:0] din,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [1:0]  ld_lo,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

`ifdef DMEM_SUBWORD_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: alignment check, byte enables and lane replication.
    always_comb begin
        misaligned = 1'b0;
        wea        = 4'hF;
        din        = req_wdata;
        unique case (req_size)
            SZ_BYTE: begin
                wea = 4'b0001 << req_lo;
                din = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                misaligned = req_lo[0];
                wea        = req_lo[1] ? 4'b1100 : 4'b0011;
                din        = {2{req_wdata[15:0]}};
            end
            default: misaligned = |req_lo;
        endcase
    end

    // Load side: pick the addressed lane, then sign- or zero-extend it.
    always_comb begin
        ld_byte = ld_raw[7:0];
        unique case (ld_lo)
            2'd1:    ld_byte = ld_raw[15:8];
            2'd2:    ld_byte = ld_raw[23:16];
            2'd3:    ld_byte = ld_raw[31:24];
            default: ld_byte = ld_raw[7:0];
        endcase
        ld_half = ld_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
        ld_data = ld_raw;
        unique case (ld_size)
            SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            default: ld_data = ld_raw;
        endcase
    end
`else
    logic unused_fmt;

    // Word-only build: every access is a full aligned word.
    always_comb begin
        misaligned = |req_lo;
        wea        = 4'hF;
        din        = req_wdata;
        ld_data    = ld_raw;
    end

    assign unused_fmt = ^{req_size, ld_size, ld_unsigned, ld_lo};
`endif

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: CPU data-port responder driving a synchronous BRAM, stalling loads.
// Build option DMEM_SUBWORD_EN enables byte/half accesses (word-only otherwise).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              addr_err,
    output logic              ram_ena,
    output logic [3:0]        ram_wea,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    localparam logic [1:0] LAT = clamp_lat(RD_LATENCY);

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        lo_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [31:0]       rdata_q;

    logic              misaligned;
    logic [3:0]        st_wea;
    logic [31:0]       st_din;
    logic [31:0]       ld_data;
    logic [ADDR_W-1:0] req_word;
    logic              accept_ld;
    logic              unused_addr;

    assign req_word    = req_addr[ADDR_W+1:2];
    assign accept_ld   = (state_q == IDLE) && req_valid
                         && !req_we && !misaligned;
    assign resp_rdata  = rdata_q;
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    dmem_lane_fmt u_fmt (
        .req_size    (req_size),
        .req_lo      (req_addr[1:0]),
        .req_wdata   (req_wdata),
        .misaligned  (misaligned),
        .wea         (st_wea),
        .din         (st_din),
        .ld_size     (size_q),
        .ld_unsigned (uns_q),
        .ld_lo       (lo_q),
        .ld_raw      (ram_dout),
        .ld_data     (ld_data)
    );

    // Next state and BRAM/CPU controls; reset forces everything idle.
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        resp_valid = 1'b0;
        addr_err   = 1'b0;
        ram_ena    = 1'b0;
        ram_wea    = 4'h0;
        ram_addr   = '0;
        ram_din    = '0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        addr_err = 1'b1;
                    end else if (req_we) begin
                        ram_ena  = 1'b1;
                        ram_wea  = st_wea;
                        ram_addr = req_word;
                        ram_din  = st_din;
                    end else begin
                        stall    = 1'b1;
                        ram_ena  = 1'b1;
                        ram_addr = req_word;
                        state_d  = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                stall    = 1'b1;
                ram_ena  = 1'b1;
                ram_addr = addr_q;
                if (cnt_q == 2'd1) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            state_d    = IDLE;
            stall      = 1'b0;
            resp_valid = 1'b0;
            addr_err   = 1'b0;
            ram_ena    = 1'b0;
            ram_wea    = 4'h0;
            ram_addr   = '0;
            ram_din    = '0;
        end
    end

    // State, captured load context, latency counter and response data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            lo_q    <= '0;
            size_q  <= SZ_WORD;
            uns_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept_ld) begin
                cnt_q  <= LAT;
                addr_q <= req_word;
                lo_q   <= req_addr[1:0];
                size_q <= req_size;
                uns_q  <= req_unsigned;
            end else if (state_q == RD_WAIT) begin
                cnt_q <= cnt_q - 2'd1;
                if (cnt_q == 2'd1) rdata_q <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder at read latencies 1 and 3.
// Expectations follow DMEM_SUBWORD_EN when it is defined for the build.
module tb_dmem_responder;
    import dmem_pkg::*;

`ifdef DMEM_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        va, vb;

    logic        stall_a, rv_a, err_a, ena_a;
    logic [3:0]  wea_a;
    logic [9:0]  addr_a;
    logic [31:0] din_a, dout_a, rdata_a;
    logic        stall_b, rv_b, err_b, ena_b;
    logic [3:0]  wea_b;
    logic [9:0]  addr_b;
    logic [31:0] din_b, dout_b, rdata_b;

    logic        stall, rv, err, ena;
    logic [3:0]  wea;
    logic [9:0]  raddr;
    logic [31:0] din, rdata;

    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    logic [31:0] pb0, pb1, pb2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign va = req_valid & ~sel;
    assign vb = req_valid & sel;

    assign stall = sel ? stall_b : stall_a;
    assign rv    = sel ? rv_b    : rv_a;
    assign err   = sel ? err_b   : err_a;
    assign ena   = sel ? ena_b   : ena_a;
    assign wea   = sel ? wea_b   : wea_a;
    assign raddr = sel ? addr_b  : addr_a;
    assign din   = sel ? din_b   : din_a;
    assign rdata = sel ? rdata_b : rdata_a;

    dmem_responder #(.ADDR_W(10), .RD_LATENCY(1)) u_a (
        .clk(clk), .rst(rst), .req_valid(va), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall_a), .resp_valid(rv_a), .resp_rdata(rdata_a),
        .addr_err(err_a), .ram_ena(ena_a), .ram_wea(wea_a),
        .ram_addr(addr_a), .ram_din(din_a), .ram_dout(dout_a)
    );

    dmem_responder #(.ADDR_W(10), .RD_LATENCY(3)) u_b (
        .clk(clk), .rst(rst), .req_valid(vb), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall_b), .resp_valid(rv_b), .resp_rdata(rdata_b),
        .addr_err(err_b), .ram_ena(ena_b), .ram_wea(wea_b),
        .ram_addr(addr_b), .ram_din(din_b), .ram_dout(dout_b)
    );

    // BRAM model, read latency 1, read-before-write.
    always @(posedge clk) begin
        if (ena_a) begin
            dout_a <= mem_a[addr_a];
            for (int i = 0; i < 4; i++)
                if (wea_a[i]) mem_a[addr_a][8*i +: 8] <= din_a[8*i +: 8];
        end
    end

    // BRAM model, read latency 3.
    always @(posedge clk) begin
        if (ena_b) begin
            pb0 <= mem_b[addr_b];
            for (int i = 0; i < 4; i++)
                if (wea_b[i]) mem_b[addr_b][8*i +: 8] <= din_b[8*i +: 8];
        end
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign dout_b = pb2;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string nm, input logic s,
                           input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] exp,
                           input int lat);
        sel          = s;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = '0;
        for (int i = 0; i <= lat; i++) begin
            #2;
            chk({nm, " stall"}, stall, 1);
            chk({nm, " rv early"}, rv, 0);
            chk({nm, " ena"}, ena, 1);
            chk({nm, " raddr"}, raddr, a[11:2]);
            tick();
        end
        #2;
        chk({nm, " rv"}, rv, 1);
        chk({nm, " resp stall"}, stall, 0);
        chk({nm, " resp ena"}, ena, 0);
        chk({nm, " rdata"}, rdata, exp);
        tick();
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic        s;
        logic        valid;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ena;
        logic [3:0]  wea;
        logic [9:0]  raddr;
        logic [31:0] din;
        logic        err;
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{0, 1, 1, SZ_WORD, 32'h10, 32'hDEADBEEF,
                    1, 4'hF, 10'd4, 32'hDEADBEEF, 0};
        tbl[1]  = '{0, 1, 1, SZ_WORD, 32'h20, 32'h80FF7F01,
                    1, 4'hF, 10'd8, 32'h80FF7F01, 0};
        tbl[2]  = '{1, 1, 1, SZ_BYTE, SUB ? 32'h21 : 32'h20,
                    32'h123456AB, 1, SUB ? 4'b0010 : 4'hF, 10'd8,
                    SUB ? 32'hABABABAB : 32'h123456AB, 0};
        tbl[3]  = '{1, 1, 1, SZ_HALF, 32'h12, 32'h00001234,
                    SUB, SUB ? 4'b1100 : 4'h0, 10'd4,
                    32'h12341234, !SUB};
        tbl[4]  = '{1, 1, 1, SZ_BYTE, 32'h23, 32'h0000005A,
                    SUB, SUB ? 4'b1000 : 4'h0, 10'd8,
                    32'h5A5A5A5A, !SUB};
        tbl[5]  = '{0, 1, 0, SZ_WORD, 32'h22, 32'h0,
                    0, 4'h0, 10'd0, 32'h0, 1};
        tbl[6]  = '{0, 1, 1, SZ_HALF, 32'h13, 32'h0000BEEF,
                    0, 4'h0, 10'd0, 32'h0, 1};
        tbl[7]  = '{1, 1, 1, 2'b11, 32'h08, 32'h11223344,
                    1, 4'hF, 10'd2, 32'h11223344, 0};
        tbl[8]  = '{0, 1, 1, 2'b11, 32'h09, 32'h11223344,
                    0, 4'h0, 10'd0, 32'h0, 1};
        tbl[9]  = '{0, 0, 1, SZ_WORD, 32'h40, 32'h77777777,
                    0, 4'h0, 10'd0, 32'h0, 0};
        tbl[10] = '{1, 1, 1, SZ_WORD, 32'h1010, 32'h5555AAAA,
                    1, 4'hF, 10'd4, 32'h5555AAAA, 0};
        tbl[11] = '{1, 1, 1, SZ_WORD, 32'h0, 32'hCAFEF00D,
                    1, 4'hF, 10'd0, 32'hCAFEF00D, 0};
        tbl[12] = '{1, 1, 1, SZ_WORD, 32'h4, 32'h0BADC0DE,
                    1, 4'hF, 10'd1, 32'h0BADC0DE, 0};

        rst          = 1'b1;
        sel          = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = SZ_WORD;
        req_unsigned = 1'b0;
        req_addr     = 32'h11;
        req_wdata    = '0;
        tick();
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("rst stall", stall, 0);
            chk("rst ena", ena, 0);
            chk("rst err", err, 0);
            chk("rst wea", wea, 0);
            chk("rst rv", rv, 0);
            req_addr = 32'h10;
            tick();
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        #2;
        chk("post-rst stall", stall, 0);
        chk("post-rst rv", rv, 0);
        chk("post-rst ena", ena, 0);
        chk("post-rst rdata", rdata, 0);
        tick();

        for (int i = 0; i < 13; i++) begin
            sel          = tbl[i].s;
            req_valid    = tbl[i].valid;
            req_we       = tbl[i].we;
            req_size     = tbl[i].size;
            req_unsigned = 1'b0;
            req_addr     = tbl[i].addr;
            req_wdata    = tbl[i].wdata;
            #2;
            chk($sformatf("vec%0d ena", i), ena, tbl[i].ena);
            chk($sformatf("vec%0d wea", i), wea, tbl[i].wea);
            chk($sformatf("vec%0d err", i), err, tbl[i].err);
            chk($sformatf("vec%0d stall", i), stall, 0);
            chk($sformatf("vec%0d rv", i), rv, 0);
            if (tbl[i].ena) begin
                chk($sformatf("vec%0d raddr", i), raddr, tbl[i].raddr);
                chk($sformatf("vec%0d din", i), din, tbl[i].din);
            end
            tick();
        end
        req_valid = 1'b0;
        tick();

        do_load("lw10", 0, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 1);
`ifdef DMEM_SUBWORD_EN
        do_load("lb22", 0, SZ_BYTE, 0, 32'h22, 32'hFFFFFFFF, 1);
        do_load("lbu22", 0, SZ_BYTE, 1, 32'h22, 32'h000000FF, 1);
        do_load("lh22", 0, SZ_HALF, 0, 32'h22, 32'hFFFF80FF, 1);
        do_load("lhu20", 0, SZ_HALF, 1, 32'h20, 32'h00007F01, 1);
        do_load("lb21", 0, SZ_BYTE, 0, 32'h21, 32'h0000007F, 1);
`else
        do_load("lb20", 0, SZ_BYTE, 0, 32'h20, 32'h80FF7F01, 1);
        do_load("lhu20", 0, SZ_HALF, 1, 32'h20, 32'h80FF7F01, 1);
`endif
        do_load("b2b0", 1, SZ_WORD, 0, 32'h0, 32'hCAFEF00D, 3);
        do_load("b2b4", 1, SZ_WORD, 0, 32'h4, 32'h0BADC0DE, 3);
        do_load("sz11", 1, 2'b11, 0, 32'h8, 32'h11223344, 3);

        sel       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = SZ_WORD;
        req_addr  = 32'h0;
        #2;
        chk("abort acc stall", stall, 1);
        tick();
        #2;
        chk("abort wait1 stall", stall, 1);
        tick();
        rst = 1'b1;
        #2;
        chk("abort rst stall", stall, 0);
        chk("abort rst rv", rv, 0);
        chk("abort rst ena", ena, 0);
        tick();
        rst       = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk($sformatf("abort idle%0d rv", i), rv, 0);
            chk($sformatf("abort idle%0d stall", i), stall, 0);
            tick();
        end
        chk("abort rdata", rdata, 0);
        do_load("after", 1, SZ_WORD, 0, 32'h4, 32'h0BADC0DE, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
